// File: rtl/prog_pulse_gen_pkg.sv
// Shared types and default sizing for the programmable multi-channel pulse generator.
package prog_pulse_gen_pkg;

    localparam int unsigned NumChDefault = 4;
    localparam int unsigned CntWDefault  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StPulse,
        StGap
    } ch_state_e;

endpackage

// File: rtl/prog_pulse_gen_if.sv
// Trigger/config inputs and pulse status outputs of the pulse generator, grouped as one bundle.
interface prog_pulse_gen_if
    import prog_pulse_gen_pkg::*;
#(
    parameter int unsigned NUM_CH = NumChDefault,
    parameter int unsigned CNT_W  = CntWDefault
) ();

    logic [NUM_CH-1:0] trigger;
    logic [NUM_CH-1:0] abort;
    logic [CNT_W-1:0]  cfg_width;
    logic [CNT_W-1:0]  cfg_gap;
    logic              cfg_retrig;
    logic [NUM_CH-1:0] pulse;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] done;

    modport master (
        output trigger,
        output abort,
        output cfg_width,
        output cfg_gap,
        output cfg_retrig,
        input  pulse,
        input  busy,
        input  done
    );

    modport slave (
        input  trigger,
        input  abort,
        input  cfg_width,
        input  cfg_gap,
        input  cfg_retrig,
        output pulse,
        output busy,
        output done
    );

endinterface

// File: rtl/prog_pulse_ch.sv
// One pulse channel: trigger edge detect, IDLE/PULSE/GAP sequencer and a saturating down-counter.
module prog_pulse_ch
    import prog_pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_W = CntWDefault
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] cfg_width_i,
    input  logic [CNT_W-1:0] cfg_gap_i,
    input  logic             cfg_retrig_i,
    output logic             pulse_o,
    output logic             busy_o,
    output logic             done_o
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic             trig_prev_q, trig_prev_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             edge_det;
    logic             last_cnt;
    logic             width_nz;
    logic             pulse_end;
    logic [CNT_W-1:0] cnt_dec;

    assign edge_det    = trigger_i & ~trig_prev_q;
    assign trig_prev_d = trigger_i;
    assign width_nz    = (cfg_width_i != '0);
    assign last_cnt    = (cnt_q <= CNT_W'(1));
    assign cnt_dec     = (cnt_q != '0) ? (cnt_q - CNT_W'(1)) : '0;

    // History resets to 1 so a trigger already high when reset drops is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            gap_q       <= '0;
            trig_prev_q <= 1'b1;
            pulse_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            trig_prev_q <= trig_prev_d;
            pulse_q     <= pulse_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        pulse_end = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (edge_det && width_nz) begin
                    state_d = StPulse;
                    cnt_d   = cfg_width_i;
                    gap_d   = cfg_gap_i;
                end
            end
            StPulse: begin
                if (abort_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (edge_det && cfg_retrig_i && width_nz) begin
                    // Reload counts the cycles still to come after this one.
                    cnt_d = cfg_width_i;
                end else if (last_cnt) begin
                    pulse_end = 1'b1;
                    if (gap_q != '0) begin
                        state_d = StGap;
                        cnt_d   = gap_q;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            StGap: begin
                if (abort_i || last_cnt) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pulse_d = (state_d == StPulse);
        busy_d  = (state_d != StIdle);
        done_d  = pulse_end;
    end

    assign pulse_o = pulse_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: rtl/prog_pulse_gen.sv
// Programmable pulse generator: NUM_CH independent channels sharing one width/gap/retrigger config.
module prog_pulse_gen
    import prog_pulse_gen_pkg::*;
#(
    parameter int unsigned NUM_CH = NumChDefault,
    parameter int unsigned CNT_W  = CntWDefault
) (
    input logic             clk,
    input logic             rst,
    prog_pulse_gen_if.slave bus
);

    logic [NUM_CH-1:0] pulse_w;
    logic [NUM_CH-1:0] busy_w;
    logic [NUM_CH-1:0] done_w;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        prog_pulse_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .trigger_i   (bus.trigger[i]),
            .abort_i     (bus.abort[i]),
            .cfg_width_i (bus.cfg_width),
            .cfg_gap_i   (bus.cfg_gap),
            .cfg_retrig_i(bus.cfg_retrig),
            .pulse_o     (pulse_w[i]),
            .busy_o      (busy_w[i]),
            .done_o      (done_w[i])
        );
    end

    assign bus.pulse = pulse_w;
    assign bus.busy  = busy_w;
    assign bus.done  = done_w;

endmodule
